// File: rtl/fir_mac_filter.sv
// fir_mac_filter
//   Time-multiplexed N-tap FIR filter. Each rising edge of the sampling clock
//   captures one signed sample into a circular buffer. One multiply-accumulate
//   then runs per clk cycle, newest sample first. The sum is scaled back by the
//   Q1.(CW-1) coefficient format (floor shift), saturated to DW bits and
//   presented on dout with a one-cycle dout_valid pulse.
//
//   Ports
//     clk, rst     system clock, asynchronous active-high reset
//     s_clk        sampling clock (synchronous to clk); its rising edge is the strobe
//     din          signed input sample, taken only on the capture edge
//     coef_we      coefficient write enable (honoured only while idle)
//     coef_addr    tap index to write
//     coef_din     signed Q1.(CW-1) coefficient value
//     ovr_clr      clears the sticky overrun flag
//     dout         signed filtered sample
//     dout_valid   one-cycle pulse when dout updates
//     busy         high while a sample is being computed
//     overrun      sticky: a strobe arrived while busy and its sample was dropped
module fir_mac_filter #(
  parameter int N_TAPS = 16,
  parameter int DW     = 12,
  parameter int CW     = 12,
  parameter int ACCW   = DW + CW + $clog2(N_TAPS)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      s_clk,
  input  logic signed [DW-1:0]      din,
  input  logic                      coef_we,
  input  logic [$clog2(N_TAPS)-1:0] coef_addr,
  input  logic signed [CW-1:0]      coef_din,
  input  logic                      ovr_clr,
  output logic signed [DW-1:0]      dout,
  output logic                      dout_valid,
  output logic                      busy,
  output logic                      overrun
);

  localparam int AW = $clog2(N_TAPS);
  localparam int PW = DW + CW;

  // Largest positive Q1.(CW-1) value: the "x1" pass-through default for tap 0.
  localparam logic signed [CW-1:0]   COEF_ONE = CW'(2**(CW-1) - 1);
  localparam logic signed [ACCW-1:0] SAT_MAX  = ACCW'(2**(DW-1) - 1);
  localparam logic signed [ACCW-1:0] SAT_MIN  = ~SAT_MAX;

  typedef enum logic [1:0] {IDLE, MAC, OUT} state_t;

  state_t                 state, state_nxt;
  logic                   s_clk_d;
  logic                   strb;
  logic signed [DW-1:0]   x    [N_TAPS];
  logic signed [CW-1:0]   coef [N_TAPS];
  logic [AW-1:0]          wr_ptr;
  logic [AW-1:0]          tap;
  logic [AW-1:0]          rd_idx;
  logic                   last_tap;
  logic signed [PW-1:0]   prod;
  logic signed [ACCW-1:0] prod_ext;
  logic signed [ACCW-1:0] acc;

  // Scale back from Q1.(CW-1) by an arithmetic (floor) shift, then clamp.
  function automatic logic signed [DW-1:0] sat_floor(input logic signed [ACCW-1:0] a);
    logic signed [ACCW-1:0] s;
    s = a >>> (CW - 1);
    if (s > SAT_MAX)
      sat_floor = SAT_MAX[DW-1:0];
    else if (s < SAT_MIN)
      sat_floor = SAT_MIN[DW-1:0];
    else
      sat_floor = s[DW-1:0];
  endfunction

  assign strb     = s_clk & ~s_clk_d;
  assign busy     = (state != IDLE);
  assign last_tap = (tap == AW'(N_TAPS - 1));

  // Tap k reads the sample k steps older than the newest; the AW-bit
  // subtraction wraps naturally around the circular buffer.
  assign rd_idx   = wr_ptr - tap;
  assign prod     = x[rd_idx] * coef[tap];
  assign prod_ext = {{(ACCW - PW){prod[PW-1]}}, prod};

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (strb) state_nxt = MAC;
      MAC:     if (last_tap) state_nxt = OUT;
      OUT:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      s_clk_d <= 1'b0;
      overrun <= 1'b0;
    end else begin
      state   <= state_nxt;
      s_clk_d <= s_clk;
      // A strobe while busy drops its sample; setting beats a same-cycle clear.
      if (strb && (state != IDLE))
        overrun <= 1'b1;
      else if (ovr_clr)
        overrun <= 1'b0;
    end
  end

  // Coefficient bank: writes land only while idle, so a write together with
  // the capture strobe is already visible to the first MAC cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < N_TAPS; i++)
        coef[i] <= (i == 0) ? COEF_ONE : '0;
    end else if ((state == IDLE) && coef_we) begin
      coef[coef_addr] <= coef_din;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < N_TAPS; i++)
        x[i] <= '0;
      wr_ptr     <= '0;
      tap        <= '0;
      acc        <= '0;
      dout       <= '0;
      dout_valid <= 1'b0;
    end else begin
      dout_valid <= 1'b0;
      case (state)
        // Capture edge: store the newest sample and clear the accumulator.
        IDLE: begin
          if (strb) begin
            x[wr_ptr] <= din;
            acc       <= '0;
            tap       <= '0;
          end
        end
        // One MAC per cycle; the pointer advances after the last tap so the
        // next capture lands in the oldest slot.
        MAC: begin
          acc <= acc + prod_ext;
          tap <= tap + 1'b1;
          if (last_tap)
            wr_ptr <= wr_ptr + 1'b1;
        end
        // Output stage: scale, clamp and publish.
        OUT: begin
          dout       <= sat_floor(acc);
          dout_valid <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule
